// File: rtl/radicador_param.sv
// radicador_param: WIDTH-bit integer square root with remainder, two operand bits per clock, START/FIN handshake.
// Optional macro RADICADOR_ROUND_EN adds a one-cycle ROUND state that rounds ROOT to nearest (saturating).
module radicador_param #(
    parameter int WIDTH = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [WIDTH-1:0]   X,
    output logic               BUSY,
    output logic               FIN,
    output logic [WIDTH/2-1:0] ROOT,
    output logic [WIDTH/2:0]   REM
);
    localparam int RW = WIDTH / 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t        state;
    logic [WIDTH-1:0] op_q;
    logic [RW-1:0] root_q;
    logic [RW:0]   rem_q;
    logic [CW-1:0] cnt_q;

    logic [RW+1:0] trial;
    logic [RW+1:0] test;
    logic          fits;
    logic [RW:0]   rem_next;
    logic [RW-1:0] root_next;

    // NOTE: every signal is assigned on every path through always_comb, so no latch can be inferred.
    always_comb begin
        // rem_q's top bit is always zero before the final iteration, so truncating it is lossless.
        trial     = (RW+2)'({rem_q, op_q[WIDTH-1 -: 2]});
        test      = {root_q, 2'b01};
        fits      = (trial >= test);
        rem_next  = fits ? (RW+1)'(trial - test) : (RW+1)'(trial);
        root_next = {root_q[RW-2:0], fits};
    end

    // NOTE: all state here is sequential, so only non-blocking assignments are used.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            op_q   <= '0;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            ROOT   <= '0;
            REM    <= '0;
            BUSY   <= 1'b0;
            FIN    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        op_q   <= X;
                        root_q <= '0;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        BUSY   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    op_q   <= {op_q[WIDTH-3:0], 2'b00};
                    root_q <= root_next;
                    rem_q  <= rem_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(RW-1)) begin
`ifdef RADICADOR_ROUND_EN
                        state <= ROUND;
`else
                        ROOT  <= root_next;
                        REM   <= rem_next;
                        BUSY  <= 1'b0;
                        FIN   <= 1'b1;
                        state <= DONE;
`endif
                    end
                end
`ifdef RADICADOR_ROUND_EN
                ROUND: begin
                    // Round up when the remainder exceeds the root, unless the root is already all ones.
                    ROOT  <= (rem_q > {1'b0, root_q} && root_q != '1) ? root_q + 1'b1 : root_q;
                    REM   <= rem_q;
                    BUSY  <= 1'b0;
                    FIN   <= 1'b1;
                    state <= DONE;
                end
`endif
                DONE: begin
                    if (!START) begin
                        FIN   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_radicador_param.sv
// Self-checking bench for radicador_param: directed WIDTH=16 cases plus a randomized WIDTH=32 sweep
// scored against a binary-search square-root model.
module tb_radicador_param;
`ifdef RADICADOR_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    typedef struct {
        longint root;
        longint rem;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic        s16 = 1'b0;
    logic [15:0] x16 = '0;
    logic        b16, f16;
    logic [7:0]  r16;
    logic [8:0]  m16;

    logic        s32 = 1'b0;
    logic [31:0] x32 = '0;
    logic        b32, f32;
    logic [15:0] r32;
    logic [16:0] m32;

    radicador_param #(.WIDTH(16)) dut16 (
        .CLK(CLK), .RESET(RESET), .START(s16), .X(x16),
        .BUSY(b16), .FIN(f16), .ROOT(r16), .REM(m16)
    );

    radicador_param #(.WIDTH(32)) dut32 (
        .CLK(CLK), .RESET(RESET), .START(s32), .X(x32),
        .BUSY(b32), .FIN(f32), .ROOT(r32), .REM(m32)
    );

    int   checks = 0;
    int   failures = 0;
    exp_t q16[$];
    exp_t q32[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint isqrt(input longint x);
        longint lo = 0;
        longint hi = 65535;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic exp_t model(input longint x, input int rw);
        exp_t   e;
        longint r = isqrt(x);
        e.rem  = x - r * r;
        e.root = (RND != 0 && e.rem > r && r < (longint'(1) << rw) - 1) ? r + 1 : r;
        return e;
    endfunction

    // Scoreboard: each FIN rising edge must match the oldest outstanding request;
    // results must never move except on a FIN rise or under reset.
    logic        f16_p = 1'b0, f32_p = 1'b0;
    logic [7:0]  r16_p = '0;
    logic [8:0]  m16_p = '0;
    logic [15:0] r32_p = '0;
    logic [16:0] m32_p = '0;

    always @(negedge CLK) begin
        exp_t e;
        if (f16 && b16) check("fin_busy16", 1, 0);
        if (f32 && b32) check("fin_busy32", 1, 0);
        if (f16 && !f16_p) begin
            if (q16.size() == 0) check("fin16_spurious", 1, 0);
            else begin
                e = q16.pop_front();
                check("root16", r16, e.root);
                check("rem16", m16, e.rem);
            end
        end else if (!RESET && (r16 !== r16_p || m16 !== m16_p))
            check("hold16", {r16, m16}, {r16_p, m16_p});
        if (f32 && !f32_p) begin
            if (q32.size() == 0) check("fin32_spurious", 1, 0);
            else begin
                e = q32.pop_front();
                check("root32", r32, e.root);
                check("rem32", m32, e.rem);
            end
        end else if (!RESET && (r32 !== r32_p || m32 !== m32_p))
            check("hold32", {r32, m32}, {r32_p, m32_p});
        f16_p = f16;
        f32_p = f32;
        r16_p = r16;
        m16_p = m16;
        r32_p = r32;
        m32_p = m32;
    end

    task automatic op16(input logic [15:0] x, input longint er, input longint em,
                        input int hold, input logic [15:0] x_late);
        int cyc = 0;
        @(negedge CLK);
        x16 = x;
        s16 = 1'b1;
        q16.push_back(model(longint'(x), 8));
        while (!f16 && cyc < 64) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 3) x16 = x_late;
        end
        // FIN is first visible on the negedge after the edge that raised it.
        check("lat16", cyc - 1, 8 + RND);
        check("root16_lit", r16, er);
        check("rem16_lit", m16, em);
        repeat (hold) @(negedge CLK);
        if (hold > 0) begin
            check("fin16_held", f16, 1);
            check("busy16_held", b16, 0);
        end
        s16 = 1'b0;
        @(negedge CLK);
        check("fin16_drop", f16, 0);
    endtask

    task automatic op32(input logic [31:0] x);
        int cyc = 0;
        @(negedge CLK);
        x32 = x;
        s32 = 1'b1;
        q32.push_back(model(longint'(x), 16));
        while (!f32 && cyc < 64) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 2) x32 = $urandom();
        end
        check("lat32", cyc - 1, 16 + RND);
        s32 = 1'b0;
        @(negedge CLK);
        check("fin32_drop", f32, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint r;
        repeat (2) @(negedge CLK);
        check("rst_root16", r16, 0);
        check("rst_rem16", m16, 0);
        check("rst_busy16", b16, 0);
        check("rst_fin16", f16, 0);
        check("rst_root32", r32, 0);
        check("rst_fin32", f32, 0);
        RESET = 1'b0;

        // Model pinned against hand-computed values.
        check("model_1000_root", isqrt(1000), 31);
        check("model_143_rem", model(143, 8).rem, 22);

        op16(16'd144, 12, 0, 2, 16'd144);
        op16(16'd143, RND ? 12 : 11, 22, 0, 16'd143);
        op16(16'd0, 0, 0, 0, 16'd0);
        op16(16'd65535, 255, 510, 0, 16'd65535);

        // Abort 4 iterations into CALC: outputs clear at once and no FIN follows.
        @(negedge CLK);
        x16 = 16'd1000;
        s16 = 1'b1;
        q16.push_back(model(1000, 8));
        repeat (5) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("abort_root", r16, 0);
        check("abort_rem", m16, 0);
        check("abort_busy", b16, 0);
        check("abort_fin", f16, 0);
        q16.delete();
        s16 = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);
        check("abort_no_fin", f16, 0);

        op16(16'd1000, RND ? 32 : 31, 39, 0, 16'd1000);
        // START held 30 cycles total; X changes mid-CALC and must be ignored.
        op16(16'd49, 7, 0, 21, 16'd81);
        op16(16'd156, 12, 12, 0, 16'd156);
        op16(16'd157, RND ? 13 : 12, 13, 0, 16'd157);

        op32(32'd0);
        op32(32'd1);
        op32(32'hFFFF_FFFF);
        op32(32'(65535 * 65535));
        op32(32'd65536);
        for (int i = 0; i < 2000; i++) begin
            if (i % 2 == 0) op32($urandom());
            else begin
                r = longint'($urandom_range(0, 65535));
                op32(32'(r * r + longint'($urandom_range(0, 2)) - 1));
            end
        end

        repeat (3) @(negedge CLK);
        check("q16_drained", q16.size(), 0);
        check("q32_drained", q32.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
